// File: rtl/elevator_request_latch.sv
`default_nettype none
// ============================================================================
// elevator_request_latch: debounced hall/car buttons -> pending request latches
// and above/here/below summaries for the scheduler.  Rev 1.0
// ============================================================================
module elevator_request_latch #(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int FW             = $clog2(N + 1)
) (
  input  logic          board_clk,
  input  logic          rst_n,
  input  logic [N:1]    request_up_button,
  input  logic [N:1]    request_down_button,
  input  logic [N:1]    input_floor_button,
  input  logic [FW-1:0] current_floor,
  input  logic          service_valid,
  input  logic [FW-1:0] service_floor,
  input  logic          service_up,
  input  logic          service_down,
  output logic [N:1]    led_up,
  output logic [N:1]    led_down,
  output logic [N:1]    car_pending,
  output logic          req_here,
  output logic          req_above,
  output logic          req_below
);

  localparam int NCH = 3 * N;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0]  FLOOR_MAX = FW'(N);
  // Channel layout: [N-1:0] hall up, [2N-1:N] hall down, [3N-1:2N] car.
  // Hall up at the top floor and hall down at floor 1 do not exist.
  localparam logic [NCH-1:0] SET_MASK  = ~((NCH'(1) << (N - 1)) | (NCH'(1) << N));

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] deb;
  logic [NCH-1:0] deb_d;
  logic [CW-1:0]  cnt [NCH];
  logic [NCH-1:0] rise;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] latch;
  logic [N:1]     pend;
  logic           sf_ok;
  logic           cf_ok;

  assign raw  = {input_floor_button, request_down_button, request_up_button};
  assign rise = deb & ~deb_d;

  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
      for (int k = 0; k < NCH; k++) begin
        if (sync2[k] != deb[k]) begin
          if (cnt[k] == CNT_LAST) begin
            deb[k] <= sync2[k];
            cnt[k] <= '0;
          end else begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end else begin
          cnt[k] <= '0;
        end
      end
    end
  end

  assign sf_ok = (service_floor != '0) && (service_floor <= FLOOR_MAX);
  assign cf_ok = (current_floor != '0) && (current_floor <= FLOOR_MAX);

  always_comb begin
    clr = '0;
    if (service_valid && sf_ok) begin
      for (int f = 1; f <= N; f++) begin
        if (FW'(f) == service_floor) begin
          clr[f - 1]         = service_up;
          clr[N + f - 1]     = service_down;
          clr[2 * N + f - 1] = 1'b1;
        end
      end
    end
  end

  // Clear dominates a coincident set: the floor is being served right now.
  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      latch <= '0;
    end else begin
      latch <= (latch | (rise & SET_MASK)) & ~clr;
    end
  end

  assign led_up      = latch[N-1:0];
  assign led_down    = latch[2*N-1:N];
  assign car_pending = latch[3*N-1:2*N];
  assign pend        = led_up | led_down | car_pending;

  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    if (cf_ok) begin
      for (int f = 1; f <= N; f++) begin
        if (FW'(f) == current_floor)     req_here  = req_here  | pend[f];
        else if (FW'(f) > current_floor) req_above = req_above | pend[f];
        else                             req_below = req_below | pend[f];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_latch.sv
`default_nettype none
// ============================================================================
// tb_elevator_request_latch: scenario tasks plus a randomized run against a
// sample-history reference model.  Rev 1.0
// ============================================================================
module tb_elevator_request_latch;

  localparam int N    = 5;
  localparam int D    = 4;
  localparam int FW   = $clog2(N + 1);
  localparam int NCH  = 3 * N;
  localparam int MAXE = 20000;

  logic          board_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic [N:1]    up_b  = '0;
  logic [N:1]    dn_b  = '0;
  logic [N:1]    car_b = '0;
  logic [FW-1:0] cur   = '0;
  logic          sv    = 1'b0;
  logic [FW-1:0] sfl   = '0;
  logic          su    = 1'b0;
  logic          sd    = 1'b0;
  logic [N:1]    led_up, led_down, car_pending;
  logic          req_here, req_above, req_below;
  logic [3*N+2:0] obs;

  elevator_request_latch #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .board_clk(board_clk), .rst_n(rst_n),
    .request_up_button(up_b), .request_down_button(dn_b), .input_floor_button(car_b),
    .current_floor(cur), .service_valid(sv), .service_floor(sfl),
    .service_up(su), .service_down(sd),
    .led_up(led_up), .led_down(led_down), .car_pending(car_pending),
    .req_here(req_here), .req_above(req_above), .req_below(req_below)
  );

  always #5 board_clk = ~board_clk;
  assign obs = {led_up, led_down, car_pending, req_here, req_above, req_below};

  // Reference model: raw samples per edge; a level is accepted once the last D
  // synchronized samples (two edges late) all disagree with the accepted level.
  bit hist [NCH][MAXE];
  bit m_latch [NCH];
  bit m_deb [NCH];
  bit m_rose [NCH];
  int ecount = 0;
  int base   = 0;
  int vectors = 0;
  int miscompares = 0;

  function automatic bit raw_of(int ch);
    if (ch < N)     return up_b[ch + 1];
    if (ch < 2 * N) return dn_b[ch - N + 1];
    return car_b[ch - 2 * N + 1];
  endfunction

  function automatic bit cleared(int ch);
    int f;
    if (!sv || int'(sfl) < 1 || int'(sfl) > N) return 1'b0;
    f = int'(sfl);
    if (ch == f - 1)         return su;
    if (ch == N + f - 1)     return sd;
    if (ch == 2 * N + f - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_edge(int e);
    bit differ, s;
    int idx;
    for (int ch = 0; ch < NCH; ch++) begin
      if (m_rose[ch] && ch != N - 1 && ch != N) m_latch[ch] = 1'b1;
      if (cleared(ch)) m_latch[ch] = 1'b0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      differ = 1'b1;
      for (int k = 0; k < D; k++) begin
        idx = e - 2 - k;
        s   = (idx < base) ? 1'b0 : hist[ch][idx];
        if (s == m_deb[ch]) differ = 1'b0;
      end
      m_rose[ch] = differ && !m_deb[ch];
      if (differ) m_deb[ch] = !m_deb[ch];
    end
  endfunction

  function automatic logic [3*N+2:0] expected();
    logic [N:1] u, d, c, p;
    logic h, a, b;
    for (int f = 1; f <= N; f++) begin
      u[f] = m_latch[f - 1];
      d[f] = m_latch[N + f - 1];
      c[f] = m_latch[2 * N + f - 1];
    end
    p = u | d | c;
    h = 1'b0; a = 1'b0; b = 1'b0;
    if (int'(cur) >= 1 && int'(cur) <= N) begin
      for (int f = 1; f <= N; f++) begin
        if (f == int'(cur))     h = p[f];
        else if (f > int'(cur)) a = a | p[f];
        else                    b = b | p[f];
      end
    end
    return {u, d, c, h, a, b};
  endfunction

  task automatic tick();
    int e = ecount;
    for (int ch = 0; ch < NCH; ch++) hist[ch][e] = raw_of(ch);
    @(posedge board_clk);
    if (rst_n) model_edge(e);
    ecount++;
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_latch[ch] = 1'b0; m_deb[ch] = 1'b0; m_rose[ch] = 1'b0;
    end
  endtask

  task automatic release_reset();
    repeat (2) begin @(posedge board_clk); ecount++; end
    @(negedge board_clk);
    rst_n = 1'b1;
    base  = ecount;
  endtask

  task automatic serve(input int f, input bit up, input bit dn);
    sv = 1'b1; sfl = FW'(f); su = up; sd = dn;
    tick();
    sv = 1'b0; su = 1'b0; sd = 1'b0;
  endtask

  task automatic test_reset();
    assert_reset();
    #2;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_async got %h want 0", obs); end
    release_reset();
    tick();
    vectors++;
    if (obs !== expected() || obs !== '0) begin
      miscompares++; $display("FAIL reset_after got %h want 0", obs);
    end
  endtask

  task automatic test_latency();
    up_b[1] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      vectors++;
      if (obs !== expected()) begin
        miscompares++; $display("FAIL latency_model tick %0d got %h want %h", i, obs, expected());
      end
      if (i == 6) begin
        vectors++;
        if (led_up !== 5'b00000) begin miscompares++; $display("FAIL latency_early got %b want 00000", led_up); end
      end
    end
    vectors++;
    if ({led_up, led_down, car_pending} !== {5'b00001, 10'b0}) begin
      miscompares++; $display("FAIL latency_set got %b want 00001", led_up);
    end
    repeat (5) tick();
    up_b = '0;
    repeat (10) tick();
    vectors++;
    if (led_up !== 5'b00001 || obs !== expected()) begin
      miscompares++; $display("FAIL latency_hold got %b want 00001", led_up);
    end
    serve(1, 1'b1, 1'b0);
    vectors++;
    if (led_up !== 5'b00000) begin miscompares++; $display("FAIL latency_clear got %b want 00000", led_up); end
  endtask

  task automatic test_glitch();
    car_b[3] = 1'b1; repeat (3) tick();
    car_b[3] = 1'b0; repeat (2) tick();
    car_b[3] = 1'b1; repeat (3) tick();
    car_b[3] = 1'b0;
    repeat (10) begin
      tick();
      vectors++;
      if (obs !== expected()) begin miscompares++; $display("FAIL glitch_model got %h want %h", obs, expected()); end
    end
    vectors++;
    if (car_pending !== 5'b00000) begin miscompares++; $display("FAIL glitch got %b want 00000", car_pending); end
  endtask

  task automatic test_summary();
    car_b[3] = 1'b1; dn_b[4] = 1'b1; repeat (8) tick();
    car_b = '0; dn_b = '0; repeat (8) tick();
    cur = 3'd3;
    #1;
    vectors++;
    if ({req_here, req_above, req_below} !== 3'b110 || obs !== expected()) begin
      miscompares++; $display("FAIL summary_pre got %b want 110", {req_here, req_above, req_below});
    end
    serve(3, 1'b0, 1'b0);
    vectors++;
    if (car_pending !== 5'b00000 || req_here !== 1'b0 || req_above !== 1'b1 || obs !== expected()) begin
      miscompares++; $display("FAIL summary_post got car=%b here=%b above=%b want 00000 0 1",
                              car_pending, req_here, req_above);
    end
    serve(4, 1'b0, 1'b1);
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL summary_cleanup got %h want 0", obs); end
  endtask

  task automatic test_partial_clear();
    up_b[2] = 1'b1; dn_b[2] = 1'b1; repeat (8) tick();
    up_b = '0; dn_b = '0; repeat (8) tick();
    serve(2, 1'b1, 1'b0);
    vectors++;
    if (led_up[2] !== 1'b0 || led_down[2] !== 1'b1 || obs !== expected()) begin
      miscompares++; $display("FAIL partial_clear got up=%b down=%b want up[2]=0 down[2]=1", led_up, led_down);
    end
    serve(2, 1'b0, 1'b1);
  endtask

  task automatic test_tied();
    up_b[5] = 1'b1; dn_b[1] = 1'b1;
    repeat (10) begin
      tick();
      vectors++;
      if (obs !== expected()) begin miscompares++; $display("FAIL tied_model got %h want %h", obs, expected()); end
    end
    up_b = '0; dn_b = '0; repeat (8) tick();
    vectors++;
    if (led_up !== 5'b0 || led_down !== 5'b0) begin
      miscompares++; $display("FAIL tied got up=%b down=%b want 0 0", led_up, led_down);
    end
  endtask

  task automatic test_back_to_back();
    car_b[2] = 1'b1;
    repeat (6) tick();
    serve(2, 1'b0, 1'b0);
    vectors++;
    if (car_pending[2] !== 1'b0 || obs !== expected()) begin
      miscompares++; $display("FAIL collision got %b want 00000", car_pending);
    end
    repeat (10) tick();
    vectors++;
    if (car_pending !== 5'b0) begin miscompares++; $display("FAIL held_no_reset got %b want 00000", car_pending); end
    car_b = '0; repeat (8) tick();
    car_b[2] = 1'b1; repeat (8) tick();
    vectors++;
    if (car_pending !== 5'b00010 || obs !== expected()) begin
      miscompares++; $display("FAIL repress got %b want 00010", car_pending);
    end
    car_b[4] = 1'b1; repeat (3) tick();
    assert_reset();
    #1;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_midcount got %h want 0", obs); end
    car_b[2] = 1'b0;
    release_reset();
    for (int i = 1; i <= 7; i++) begin
      tick();
      vectors++;
      if (obs !== expected()) begin
        miscompares++; $display("FAIL held_through_reset tick %0d got %h want %h", i, obs, expected());
      end
    end
    vectors++;
    if (car_pending !== 5'b01000) begin miscompares++; $display("FAIL reaccept got %b want 01000", car_pending); end
    car_b = '0; repeat (8) tick();
    serve(4, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int f = 1; f <= N; f++) begin
        if ($urandom_range(0, 9) == 0) up_b[f]  = ~up_b[f];
        if ($urandom_range(0, 9) == 0) dn_b[f]  = ~dn_b[f];
        if ($urandom_range(0, 9) == 0) car_b[f] = ~car_b[f];
      end
      sv  = ($urandom_range(0, 5) == 0);
      sfl = FW'($urandom_range(0, 7));
      su  = 1'($urandom_range(0, 1));
      sd  = 1'($urandom_range(0, 1));
      cur = FW'($urandom_range(0, 7));
      if (i == 750) begin
        assert_reset();
        #1;
        vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL random_reset got %h want 0", obs); end
        release_reset();
      end
      tick();
      vectors++;
      if (obs !== expected()) begin
        miscompares++; $display("FAIL random iter %0d got %h want %h", i, obs, expected());
      end
    end
    sv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_summary();
    test_partial_clear();
    test_tied();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/elevator_request_latch.md
Name: elevator_request_latch

Overview:
- Front end of the elevator request interface: conditions the raw hall and car buttons, latches them as pending requests, drives the hall call LEDs, and clears each request when the controller reports servicing it.
- Also supplies the controller with registered pending masks and combinational above/here/below summaries relative to the current floor.
- Sits between the board buttons and elevator_module's scheduling FSM.

Parameters:
N, 5, number of floors (floors numbered 1..N); N >= 2
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change; >= 1
FW (localparam), $clog2(N+1), floor-number width (3 for N=5)

Ports:
board_clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
request_up_button  input  [N:1]  raw hall up buttons, asynchronous
request_down_button  input  [N:1]  raw hall down buttons, asynchronous
input_floor_button  input  [N:1]  raw car-panel floor buttons, asynchronous
current_floor  input  [FW-1:0]  controller's current floor, 1..N
service_valid  input  1  one-cycle strobe: doors opening at service_floor
service_floor  input  [FW-1:0]  floor being serviced
service_up  input  1  with service_valid: clear hall up call at service_floor
service_down  input  1  with service_valid: clear hall down call at service_floor
led_up  output  [N:1]  pending hall up calls, registered
led_down  output  [N:1]  pending hall down calls, registered
car_pending  output  [N:1]  pending car calls, registered
req_here  output  1  any pending bit at current_floor
req_above  output  1  any pending bit at a floor > current_floor
req_below  output  1  any pending bit at a floor < current_floor

Behaviour:
- Reset (async, rst_n=0): all sync flops, debounce counters, debounced levels, led_up, led_down, car_pending = 0. req_* therefore 0.
- Per button, 3N channels: 2-flop synchronizer, then a debounce counter. The debounced level changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch gap restarts the count.
- A debounced 0->1 edge sets the latch bit on the next clock.
- Latency: button first sampled high at edge 0 and held -> latch bit is 1 after edge 2+DEBOUNCE_CYCLES (edge 6 at default).
- Pulses shorter than DEBOUNCE_CYCLES cycles after synchronization are ignored.
- A held button sets the latch exactly once. If the bit is cleared while the button is still held, it does not re-set until the button is released (debounced low) and pressed again.
- Tied-off bits: led_down[1] and led_up[N] are constant 0. Their buttons are ignored.
- Clear on service: when service_valid=1 and service_floor=f (1..N):
  - car_pending[f] clears unconditionally.
  - led_up[f] clears if service_up=1.
  - led_down[f] clears if service_down=1.
  - Takes effect on the same edge.
- Out-of-range service_floor (0 or >N): service_valid is ignored.
- Simultaneous set and clear of the same bit on one edge: clear wins (the call is being served now). Sets and clears on different bits both apply.
- Pending mask P[f] = led_up[f] | led_down[f] | car_pending[f].
- Summaries are combinational from the registers and current_floor:
  - req_here = P[current_floor]
  - req_above = OR of P[f] for f > current_floor
  - req_below = OR of P[f] for f < current_floor
  - If current_floor is 0 or >N, all three are 0.
- Reset mid-debounce or with pending calls: everything returns to 0 immediately. A button held through reset release is re-accepted as a new press after 2+DEBOUNCE_CYCLES edges.

Test Plan:
- Reset, then hold request_up_button[1] high -> led_up=5'b00001 exactly after edge 6. The bit stays at 1 while held and after release. Other outputs stay 0.
- 3-cycle pulse on input_floor_button[3], then a 2-cycle gap, then another 3-cycle pulse -> car_pending stays 5'b00000.
- Pending car_pending[3] and led_down[4], current_floor=3 -> req_here=1, req_above=1, req_below=0. Drive service_valid=1, service_floor=3 for one cycle -> car_pending=0, req_here=0, req_above=1.
- led_up[2]=led_down[2]=1, service_valid with service_floor=2, service_up=1, service_down=0 -> led_up[2]=0, led_down[2]=1.
- Debounced edge of request_up_button[5] and request_down_button[1] -> led_up and led_down stay 0.
- Hold input_floor_button[2]; service floor 2 on the same edge the latch would set -> bit stays 0. Keep holding -> no re-set. Release and re-press -> car_pending[2]=1. Assert rst_n=0 mid-count -> all outputs 0 asynchronously.
